// File: rtl/apb_master_arbiter.sv
// APB master that shares one APB bus among NUM_REQ requesters with round-robin
// arbitration, registered SETUP/ACCESS sequencing and a PREADY timeout.
module apb_master_arbiter #(
    parameter int APB_AW      = 32,
    parameter int APB_DW      = 32,
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*APB_AW-1:0] req_addr,
    input  logic [NUM_REQ*APB_DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [APB_DW-1:0]         resp_rdata,
    output logic                      resp_err,
    output logic [APB_AW-1:0]         paddr,
    output logic                      pwrite,
    output logic [APB_DW-1:0]         pwdata,
    output logic                      psel,
    output logic                      penable,
    input  logic [APB_DW-1:0]         prdata,
    input  logic                      pready,
    output logic [1:0]                fsm_state
);
    // Handshake: req_valid[i] is a level held until the one-cycle req_ack[i]
    // pulse; a level still high the cycle after req_ack is a fresh request.
    // Each accepted request yields exactly one resp_valid[i] pulse unless reset.
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

    state_t              state, state_n;
    logic [IW-1:0]       gnt, gnt_n, rr, rr_n, arb_idx, probe;
    logic [CW-1:0]       cnt, cnt_n;
    logic [NUM_REQ-1:0]  cand;
    logic                arb_found, timed_out, complete, start;
    logic [NUM_REQ-1:0]  req_ack_n, resp_valid_n;
    logic [APB_DW-1:0]   resp_rdata_n, pwdata_n;
    logic [APB_AW-1:0]   paddr_n;
    logic                resp_err_n, pwrite_n, psel_n, penable_n;

    assign fsm_state = state;

    // The owner of a completing transfer is skipped so it cannot be re-granted
    // before its own resp_valid pulse.
    always_comb begin
        cand = req_valid;
        if (state == ACCESS) cand[gnt] = 1'b0;
        arb_found = 1'b0;
        arb_idx   = '0;
        probe     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            probe = IW'((int'(rr) + i) % NUM_REQ);
            if (cand[probe]) begin
                arb_found = 1'b1;
                arb_idx   = probe;
            end
        end
    end

    assign timed_out = (TIMEOUT_CYC != 0) && (cnt == CNT_LAST) && !pready;
    assign complete  = (state == ACCESS) && (pready || timed_out);
    assign start     = ((state == IDLE) || complete) && arb_found;

    always_comb begin
        state_n      = state;
        gnt_n        = gnt;
        rr_n         = rr;
        cnt_n        = cnt;
        paddr_n      = paddr;
        pwrite_n     = pwrite;
        pwdata_n     = pwdata;
        psel_n       = psel;
        penable_n    = penable;
        req_ack_n    = '0;
        resp_valid_n = '0;
        resp_rdata_n = '0;
        resp_err_n   = 1'b0;
        case (state)
            SETUP: begin
                state_n   = ACCESS;
                penable_n = 1'b1;
                cnt_n     = '0;
            end
            ACCESS: begin
                if (complete) begin
                    resp_valid_n = NUM_REQ'(1) << gnt;
                    resp_err_n   = !pready;
                    resp_rdata_n = (pready && !pwrite) ? prdata : '0;
                    state_n      = IDLE;
                    psel_n       = 1'b0;
                    penable_n    = 1'b0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: ;
        endcase
        if (start) begin
            state_n   = SETUP;
            psel_n    = 1'b1;
            penable_n = 1'b0;
            gnt_n     = arb_idx;
            rr_n      = IW'((int'(arb_idx) + 1) % NUM_REQ);
            paddr_n   = req_addr[int'(arb_idx)*APB_AW +: APB_AW];
            pwrite_n  = req_write[arb_idx];
            pwdata_n  = req_write[arb_idx] ? req_wdata[int'(arb_idx)*APB_DW +: APB_DW] : '0;
            req_ack_n = NUM_REQ'(1) << arb_idx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            gnt        <= '0;
            rr         <= '0;
            cnt        <= '0;
            paddr      <= '0;
            pwrite     <= 1'b0;
            pwdata     <= '0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            req_ack    <= '0;
            resp_valid <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state      <= state_n;
            gnt        <= gnt_n;
            rr         <= rr_n;
            cnt        <= cnt_n;
            paddr      <= paddr_n;
            pwrite     <= pwrite_n;
            pwdata     <= pwdata_n;
            psel       <= psel_n;
            penable    <= penable_n;
            req_ack    <= req_ack_n;
            resp_valid <= resp_valid_n;
            resp_rdata <= resp_rdata_n;
            resp_err   <= resp_err_n;
        end
    end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Randomized bench for apb_master_arbiter: requesters and an APB slave are driven
// at the falling edge and checked against a transfer-level reference model.
module tb_apb_master_arbiter;
    localparam int NUM = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TO  = 16;

    logic              clk, reset_n;
    logic [NUM-1:0]    req_valid, req_write, req_ack, resp_valid;
    logic [NUM*AW-1:0] req_addr;
    logic [NUM*DW-1:0] req_wdata;
    logic [DW-1:0]     resp_rdata, pwdata, prdata;
    logic [AW-1:0]     paddr;
    logic              resp_err, pwrite, psel, penable, pready;
    logic [1:0]        fsm_state;

    apb_master_arbiter #(.APB_AW(AW), .APB_DW(DW), .NUM_REQ(NUM), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ack(req_ack),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .psel(psel), .penable(penable),
        .prdata(prdata), .pready(pready), .fsm_state(fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Requester-side stimulus state
    logic [AW-1:0] r_addr[NUM];
    logic [DW-1:0] r_wdata[NUM];
    logic          r_write[NUM];
    int            req_rate, again_rate;

    // Reference model: bus owner, phase of the transfer and expected outputs
    int            m_phase;     // 0 bus free, 1 setup cycle, 2 access cycles
    int            m_cnt, m_owner, m_rr, m_wait;
    logic          m_write;
    logic [NUM-1:0] e_ack, e_rv;
    logic          e_psel, e_penable, e_pwrite;
    logic [AW-1:0] e_paddr;
    logic [DW-1:0] e_pwdata;
    logic [DW:0]   exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic pack_reqs();
        for (int i = 0; i < NUM; i++) begin
            req_addr[i*AW +: AW]  = r_addr[i];
            req_wdata[i*DW +: DW] = r_wdata[i];
            req_write[i]          = r_write[i];
        end
    endtask

    task automatic new_request(input int i);
        r_addr[i]    = $urandom;
        r_wdata[i]   = $urandom;
        r_write[i]   = 1'($urandom_range(0, 1));
        req_valid[i] = 1'b1;
    endtask

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_owner = 0; m_rr = 0; m_wait = 0; m_write = 1'b0;
        e_ack = '0; e_rv = '0; e_psel = 1'b0; e_penable = 1'b0;
        e_pwrite = 1'b0; e_paddr = '0; e_pwdata = '0;
        exp_q.delete();
    endtask

    // Predicts what the next rising edge does, given the inputs now on the pins.
    task automatic model_step();
        bit may_grant, done, found;
        int c, sel;
        may_grant = 0; done = 0; found = 0; c = 0;
        e_ack = '0;
        e_rv  = '0;
        if (m_phase == 0) begin
            may_grant = 1;
        end else if (m_phase == 1) begin
            m_phase = 2; m_cnt = 0; e_penable = 1'b1;
        end else begin
            if (pready) begin
                done = 1;
                exp_q.push_back({1'b0, m_write ? 32'd0 : prdata});
            end else if (m_cnt == TO - 1) begin
                done = 1;
                exp_q.push_back({1'b1, 32'd0});
            end else begin
                m_cnt++;
            end
            if (done) begin
                e_rv = NUM'(1) << m_owner;
                m_phase = 0; e_psel = 1'b0; e_penable = 1'b0;
                may_grant = 1;
            end
        end
        if (may_grant) begin
            for (int i = 0; i < NUM; i++) begin
                if (!found) begin
                    c = (m_rr + i) % NUM;
                    if (req_valid[c] && !(done && c == m_owner)) found = 1;
                end
            end
        end
        if (found) begin
            m_owner = c; m_phase = 1; m_rr = (c + 1) % NUM;
            e_psel = 1'b1; e_penable = 1'b0;
            e_paddr = r_addr[c]; e_pwrite = r_write[c]; m_write = r_write[c];
            e_pwdata = r_write[c] ? r_wdata[c] : '0;
            e_ack = NUM'(1) << c;
            sel = $urandom_range(0, 99);
            if (sel < 55)      m_wait = $urandom_range(0, 3);
            else if (sel < 70) m_wait = TO - 1;
            else if (sel < 85) m_wait = TO + 4;
            else               m_wait = $urandom_range(4, TO - 2);
        end
    endtask

    task automatic drive_and_step();
        for (int i = 0; i < NUM; i++) begin
            if (e_ack[i]) begin
                if ($urandom_range(0, 99) < again_rate) new_request(i);
                else req_valid[i] = 1'b0;
            end else if (!req_valid[i] && $urandom_range(0, 99) < req_rate) begin
                new_request(i);
            end
        end
        pack_reqs();
        pready = (m_phase == 2) ? (m_cnt == m_wait) : 1'($urandom_range(0, 1));
        prdata = $urandom;
        model_step();
    endtask

    task automatic check_outputs();
        logic [DW:0] exp;
        check_eq("psel", 32'(psel), 32'(e_psel));
        check_eq("penable", 32'(penable), 32'(e_penable));
        check_eq("req_ack", 32'(req_ack), 32'(e_ack));
        check_eq("resp_valid", 32'(resp_valid), 32'(e_rv));
        if (e_psel) begin
            check_eq("paddr", paddr, e_paddr);
            check_eq("pwrite", 32'(pwrite), 32'(e_pwrite));
            check_eq("pwdata", pwdata, e_pwdata);
        end
        if (e_rv != '0 && exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check_eq("resp_err", 32'(resp_err), 32'(exp[DW]));
            check_eq("resp_rdata", resp_rdata, exp[DW-1:0]);
        end
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_outputs();
            drive_and_step();
        end
    endtask

    initial begin
        int guard;
        reset_n = 1'b0; req_valid = '0; pready = 1'b0; prdata = '0;
        for (int i = 0; i < NUM; i++) begin
            r_addr[i] = '0; r_wdata[i] = '0; r_write[i] = 1'b0;
        end
        pack_reqs();
        model_reset();
        req_rate = 30; again_rate = 20;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_psel", 32'(psel), 32'd0);
        check_eq("rst_penable", 32'(penable), 32'd0);
        check_eq("rst_req_ack", 32'(req_ack), 32'd0);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_paddr", paddr, 32'd0);
        check_eq("rst_pwdata", pwdata, 32'd0);
        check_eq("rst_resp_rdata", resp_rdata, 32'd0);
        check_eq("rst_resp_err", 32'(resp_err), 32'd0);
        reset_n = 1'b1;
        drive_and_step();

        run_cycles(1500);
        // Saturated traffic: every requester re-requests immediately
        req_rate = 100; again_rate = 100;
        run_cycles(200);
        req_rate = 30; again_rate = 20;

        // Reset in the middle of an ACCESS phase
        guard = 0;
        while (m_phase != 2 && guard < 100) begin
            run_cycles(1);
            guard++;
        end
        #7;
        check_eq("pre_rst_penable", 32'(penable), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_psel", 32'(psel), 32'd0);
        check_eq("async_rst_penable", 32'(penable), 32'd0);
        @(negedge clk);
        check_eq("rst_no_resp", 32'(resp_valid), 32'd0);
        check_eq("rst_no_ack", 32'(req_ack), 32'd0);
        reset_n = 1'b1;
        model_reset();
        req_valid = '0;
        new_request(0);
        pack_reqs();
        pready = 1'b0;
        model_step();

        req_rate = 10; again_rate = 10;
        run_cycles(800);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
